// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a single-clock FIFO.
//
// Drives the write/read strobes and addresses of an external dual-port
// storage array, and reports occupancy, full/empty/almost flags and
// one-cycle overflow/underflow error pulses.
//
// Ports:
//   clk          clock, all state on posedge
//   rst          asynchronous active-high reset
//   push / pop   producer write request / consumer read request
//   wr_en        write strobe (combinational, same cycle as push)
//   wr_addr      write address
//   rd_en        read strobe (combinational, same cycle as pop)
//   rd_addr      read address
//   count        occupancy, 0..DEPTH
//   full, empty, almost_full, almost_empty   occupancy flags
//   overflow     registered pulse: a push was rejected last cycle
//   underflow    registered pulse: a pop was rejected last cycle
module fifo_ctrl #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] AfCount = CW'(AF_LEVEL);
  localparam logic [AW:0] AeCount = CW'(AE_LEVEL);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        overflow_q, underflow_q;

  always_comb begin
    count        = wr_ptr_q - rd_ptr_q;
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    almost_full  = (count >= AfCount);
    almost_empty = (count <= AeCount);
    // A push at full is still accepted when a pop frees a slot the same
    // cycle; the array is read-before-write so the slot can be reused.
    wr_en        = push & (~full | pop);
    rd_en        = pop & ~empty;
    wr_addr      = wr_ptr_q[AW-1:0];
    rd_addr      = rd_ptr_q[AW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_q + {{AW{1'b0}}, wr_en};
      rd_ptr_q    <= rd_ptr_q + {{AW{1'b0}}, rd_en};
      overflow_q  <= push & ~wr_en;
      underflow_q <= pop & ~rd_en;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for a synchronous single-clock FIFO. It sits between producer/consumer push/pop requests and a dual-port storage array. It generates the write/read enables and addresses, occupancy count, full/empty/almost flags, and per-cycle overflow/underflow error pulses. The testbench's concurrent assertions ("push when not full", "pop when not empty") check its outputs.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 2
- AW, $clog2(DEPTH), address width (derived; do not override)
- AF_LEVEL, DEPTH-2, count at or above which almost_full asserts
- AE_LEVEL, 2, count at or below which almost_empty asserts

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  reset; asynchronous, active-high
- push  input  1  producer write request
- pop  input  1  consumer read request
- wr_en  output  1  storage write strobe (combinational)
- wr_addr  output  AW  storage write address = wr_ptr[AW-1:0]
- rd_en  output  1  storage read strobe (combinational)
- rd_addr  output  AW  storage read address = rd_ptr[AW-1:0]
- count  output  AW+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- overflow  output  1  registered one-cycle pulse: push rejected last cycle
- underflow  output  1  registered one-cycle pulse: pop rejected last cycle

## Operation
- State is held in wr_ptr and rd_ptr, each AW+1 bits. The MSB is the wrap bit.
- count = wr_ptr − rd_ptr, modulo 2^(AW+1).
- full = (addresses equal) and (wrap bits differ). empty = (pointers fully equal).
- Acceptance, combinational from the current flags:
  - wr_en = push & (!full | pop)
  - rd_en = pop & !empty
- Full with push and pop in the same cycle: both are accepted. The storage is read-before-write. Count stays at DEPTH.
- Empty with push and pop in the same cycle: only the push is accepted. underflow pulses the next cycle. Count becomes 1.
- Pointer update on posedge:
  - wr_ptr += wr_en
  - rd_ptr += rd_en
  - Wrap is natural modulo 2^(AW+1). The address wraps DEPTH−1 → 0.
- overflow <= push & !wr_en
- underflow <= pop & !rd_en
- The controller never blocks or stalls. Rejected requests are dropped and reported only through the error pulses.
- Reset mid-operation: all state clears immediately and asynchronously. Contents of the storage array become don't-care. Requests in the reset cycle are ignored.

## Timing
Reset values:
- wr_ptr = 0, rd_ptr = 0, count = 0
- empty = 1, almost_empty = 1
- full = 0, almost_full = 0
- overflow = 0, underflow = 0
- wr_en = rd_en = 0 while push/pop are low

Latency and flag behaviour:
- wr_en and rd_en have zero latency: same cycle as push/pop.
- count and flags reflect an accepted request one cycle after the posedge that samples it.
- Error pulses assert exactly one cycle after the rejected request and last one cycle per rejected request. Back-to-back rejections give a continuous high.
- Flags are derived combinationally from the registered pointers only. They are glitch-free relative to push/pop.
- First posedge after rst deasserts: operation resumes normally.

## Test plan
- **Reset:** assert rst mid-burst at count=5 → same timestep: count=0, empty=1, full=0, overflow=underflow=0.
- **Fill/drain, DEPTH=8:**
  - 8 pushes from empty → full=1 after the 8th posedge; almost_full first rises at count=6.
  - 9th push → wr_en=0, overflow=1 for one cycle, count stays 8.
  - 8 pops → empty=1; a 9th pop → underflow=1, rd_en=0.
- **Wrap-around:** 5 pushes, 5 pops, 6 pushes → wr_addr sequence 5,6,7,0,1,2. count=6. The wrap bit toggles on both pointers at the correct points.
- **Simultaneous at boundaries:**
  - full, push+pop → wr_en=rd_en=1, count stays 8, no overflow.
  - empty, push+pop → wr_en=1, rd_en=0, count=1, underflow=1 next cycle.
- **Random push/pop, 1000 cycles, scoreboard model:**
  - count always matches the model.
  - Concurrent assertions hold: `wr_en |-> !full || pop`, `rd_en |-> !empty`, `!(full && empty)`.
